// File: rtl/constants_pkg.sv
// Shared constants for the ALU blocks.
//   aluSel_e : 2-bit operation select (ADD=0, SUB=1, AND=2, OR=3).
package constants_pkg;

   typedef enum logic [1:0] {
      AluAdd = 2'd0,
      AluSub = 2'd1,
      AluAnd = 2'd2,
      AluOr  = 2'd3
   } aluSel_e;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU, results modulo 2^DWIDTH.
//   sel_i          : operation select (aluSel_e)
//   op1_i, op2_i   : operands
//   res_o          : result
//   zero_o / neg_o : result == 0 / result MSB
module alu
   import constants_pkg::*;
#(
   parameter int unsigned DWIDTH = 8
) (
   input  aluSel_e           sel_i,
   input  logic [DWIDTH-1:0] op1_i,
   input  logic [DWIDTH-1:0] op2_i,
   output logic [DWIDTH-1:0] res_o,
   output logic              zero_o,
   output logic              neg_o
);

   always_comb begin
      res_o = '0;
      unique case (sel_i)
         AluAdd:  res_o = op1_i + op2_i;
         AluSub:  res_o = op1_i - op2_i;
         AluAnd:  res_o = op1_i & op2_i;
         AluOr:   res_o = op1_i | op2_i;
         default: res_o = '0;
      endcase
      zero_o = (res_o == '0);
      neg_o  = res_o[DWIDTH-1];
   end

endmodule

// File: rtl/alu_issue.sv
// Command queue in front of an ALU with a registered, handshaked result.
//   clk, rst                : clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o : command handshake; cmd_sel_i, cmd_op1_i, cmd_op2_i payload
//   res_valid_o/res_ready_i : result handshake; res_o, zero_o, neg_o registered result
//   count_o                 : queue occupancy, result register not included
module alu_issue
   import constants_pkg::*;
#(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  aluSel_e                  cmd_sel_i,
   input  logic [DWIDTH-1:0]        cmd_op1_i,
   input  logic [DWIDTH-1:0]        cmd_op2_i,
   output logic                     res_valid_o,
   input  logic                     res_ready_i,
   output logic [DWIDTH-1:0]        res_o,
   output logic                     zero_o,
   output logic                     neg_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   aluSel_e             sel_mem_q [DEPTH];
   logic [DWIDTH-1:0]   op1_mem_q [DEPTH];
   logic [DWIDTH-1:0]   op2_mem_q [DEPTH];

   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]     count_q, count_d;
   logic                res_valid_q, res_valid_d;
   logic [DWIDTH-1:0]   res_q, res_d;
   logic                zero_q, zero_d;
   logic                neg_q, neg_d;

   logic                push, pop;
   logic [DWIDTH-1:0]   alu_res;
   logic                alu_zero, alu_neg;

   // The ALU only ever sees the queue head; there is no bypass from the command port.
   alu #(
      .DWIDTH (DWIDTH)
   ) u_alu (
      .sel_i  (sel_mem_q[rd_ptr_q]),
      .op1_i  (op1_mem_q[rd_ptr_q]),
      .op2_i  (op2_mem_q[rd_ptr_q]),
      .res_o  (alu_res),
      .zero_o (alu_zero),
      .neg_o  (alu_neg)
   );

   assign cmd_ready_o = (count_q < CntW'(DEPTH));
   assign push        = cmd_valid_i && cmd_ready_o;
   assign pop         = (count_q != '0) && (!res_valid_q || res_ready_i);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      res_valid_d = res_valid_q;
      res_d       = res_q;
      zero_d      = zero_q;
      neg_d       = neg_q;

      // Pointers wrap naturally since DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);

      if (pop) begin
         res_valid_d = 1'b1;
         res_d       = alu_res;
         zero_d      = alu_zero;
         neg_d       = alu_neg;
      end else if (res_valid_q && res_ready_i) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         res_valid_q <= 1'b0;
         res_q       <= '0;
         zero_q      <= 1'b1;
         neg_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         res_valid_q <= res_valid_d;
         res_q       <= res_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
      end
   end

   // Storage needs no reset: entries are only read once the pointers say they are valid.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         sel_mem_q[wr_ptr_q] <= cmd_sel_i;
         op1_mem_q[wr_ptr_q] <= cmd_op1_i;
         op2_mem_q[wr_ptr_q] <= cmd_op2_i;
      end
   end

   assign res_valid_o = res_valid_q;
   assign res_o       = res_q;
   assign zero_o      = zero_q;
   assign neg_o       = neg_q;
   assign count_o     = count_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
   import constants_pkg::*;

   localparam int unsigned DW = 8;
   localparam int unsigned DP = 4;

   logic          clk;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   aluSel_e       cmd_sel;
   logic [DW-1:0] cmd_op1;
   logic [DW-1:0] cmd_op2;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res;
   logic          zero;
   logic          neg;
   logic [2:0]    count;

   alu_issue #(
      .DWIDTH (DW),
      .DEPTH  (DP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_sel_i   (cmd_sel),
      .cmd_op1_i   (cmd_op1),
      .cmd_op2_i   (cmd_op2),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .res_o       (res),
      .zero_o      (zero),
      .neg_o       (neg),
      .count_o     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // All driving and sampling happens 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] ref_alu(input aluSel_e s, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      case (s)
         AluAdd:  return a + b;
         AluSub:  return a - b;
         AluAnd:  return a & b;
         default: return a | b;
      endcase
   endfunction

   // One command into an idle block with res_ready=1.
   task automatic send_one(input string tag, input aluSel_e s, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] e_res,
                           input logic e_zero, input logic e_neg);
      cmd_sel   = s;
      cmd_op1   = a;
      cmd_op2   = b;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      check_eq({tag, "_cnt1"}, 32'(count), 1);
      check_eq({tag, "_notyet"}, 32'(res_valid), 0);
      step();
      check_eq({tag, "_valid"}, 32'(res_valid), 1);
      check_eq({tag, "_res"}, 32'(res), 32'(e_res));
      check_eq({tag, "_zero"}, 32'(zero), 32'(e_zero));
      check_eq({tag, "_neg"}, 32'(neg), 32'(e_neg));
      step();
      check_eq({tag, "_taken"}, 32'(res_valid), 0);
   endtask

   logic [DW-1:0] exp_q[$];
   logic          m_valid;
   logic [DW-1:0] m_res;
   int            sent, got, cyc;
   logic          m_push, m_pop;

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_sel   = AluAdd;
      cmd_op1   = '0;
      cmd_op2   = '0;
      res_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_eq("rst_count", 32'(count), 0);
      check_eq("rst_ready", 32'(cmd_ready), 1);
      check_eq("rst_valid", 32'(res_valid), 0);
      check_eq("rst_res", 32'(res), 0);
      check_eq("rst_zero", 32'(zero), 1);
      check_eq("rst_neg", 32'(neg), 0);

      // Directed single operations.
      res_ready = 1'b1;
      send_one("add_1_2", AluAdd, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
      send_one("sub_0_1", AluSub, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1);
      send_one("sub_5_5", AluSub, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0);
      send_one("and_f0_0f", AluAnd, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0);
      send_one("or_80_01", AluOr, 8'h80, 8'h01, 8'h81, 1'b0, 1'b1);
      send_one("add_wrap", AluAdd, 8'hFF, 8'h02, 8'h01, 1'b0, 1'b0);

      // Back-pressure: six offered, five accepted (four queued plus one in the result reg).
      res_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cmd_sel   = AluAdd;
         cmd_op1   = 8'(10 + i);
         cmd_op2   = 8'(i);
         cmd_valid = 1'b1;
         step();
      end
      cmd_valid = 1'b0;
      check_eq("full_count", 32'(count), 4);
      check_eq("full_ready", 32'(cmd_ready), 0);
      check_eq("full_valid", 32'(res_valid), 1);
      check_eq("full_res", 32'(res), 10);
      cmd_valid = 1'b1;
      cmd_op1   = 8'hEE;
      step();
      cmd_valid = 1'b0;
      step();
      check_eq("hold_res", 32'(res), 10);
      check_eq("hold_valid", 32'(res_valid), 1);
      check_eq("hold_count", 32'(count), 4);
      res_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         step();
         check_eq("drain_valid", 32'(res_valid), 1);
         check_eq("drain_res", 32'(res), 32'(10 + 2 * k));
      end
      step();
      check_eq("drain_done_valid", 32'(res_valid), 0);
      check_eq("drain_done_count", 32'(count), 0);

      // Streaming: one result per cycle, no bubbles.
      for (int j = 0; j <= 8; j++) begin
         if (j < 8) begin
            cmd_sel   = AluAdd;
            cmd_op1   = 8'(j);
            cmd_op2   = 8'(j);
            cmd_valid = 1'b1;
         end else begin
            cmd_valid = 1'b0;
         end
         step();
         check_eq("tp_count_le1", 32'(count <= 3'd1), 1);
         if (j >= 1) begin
            check_eq("tp_valid", 32'(res_valid), 1);
            check_eq("tp_res", 32'(res), 32'(2 * (j - 1)));
         end
      end
      step();
      check_eq("tp_end_valid", 32'(res_valid), 0);

      // Reset mid-operation, with a command offered on the reset edge.
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cmd_sel   = AluAdd;
         cmd_op1   = 8'(50 + i);
         cmd_op2   = 8'h00;
         cmd_valid = 1'b1;
         step();
      end
      check_eq("pre_rst_count", 32'(count), 3);
      check_eq("pre_rst_res", 32'(res), 50);
      cmd_op1 = 8'd99;
      rst     = 1'b1;
      step();
      rst       = 1'b0;
      cmd_valid = 1'b0;
      check_eq("mid_rst_valid", 32'(res_valid), 0);
      check_eq("mid_rst_count", 32'(count), 0);
      check_eq("mid_rst_ready", 32'(cmd_ready), 1);
      check_eq("mid_rst_zero", 32'(zero), 1);
      check_eq("mid_rst_res", 32'(res), 0);
      res_ready = 1'b1;
      send_one("post_rst", AluAdd, 8'd7, 8'd0, 8'd7, 1'b0, 1'b0);
      step();
      check_eq("post_rst_quiet", 32'(res_valid), 0);

      // Random traffic against a cycle model.
      m_valid = 1'b0;
      m_res   = '0;
      sent    = 0;
      got     = 0;
      cyc     = 0;
      while (got < 200 && cyc < 4000) begin
         cmd_valid = (sent < 200) && ($urandom_range(0, 2) != 0);
         cmd_sel   = aluSel_e'($urandom_range(0, 3));
         cmd_op1   = 8'($urandom_range(0, 255));
         cmd_op2   = 8'($urandom_range(0, 255));
         res_ready = ($urandom_range(0, 2) != 0);
         check_eq("rnd_ready", 32'(cmd_ready), 32'(exp_q.size() < DP));
         check_eq("rnd_count", 32'(count), 32'(exp_q.size()));
         check_eq("rnd_valid", 32'(res_valid), 32'(m_valid));
         if (m_valid) begin
            check_eq("rnd_res", 32'(res), 32'(m_res));
            check_eq("rnd_zero", 32'(zero), 32'(m_res == '0));
            check_eq("rnd_neg", 32'(neg), 32'(m_res[DW-1]));
         end
         m_push = cmd_valid && (exp_q.size() < DP);
         m_pop  = (exp_q.size() > 0) && (!m_valid || res_ready);
         if (m_valid && res_ready) got++;
         if (m_pop) begin
            m_res   = exp_q.pop_front();
            m_valid = 1'b1;
         end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
         end
         if (m_push) begin
            exp_q.push_back(ref_alu(cmd_sel, cmd_op1, cmd_op2));
            sent++;
         end
         step();
         cyc++;
      end
      cmd_valid = 1'b0;
      check_eq("rnd_all_results", 32'(got), 200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
